// File: rtl/uart_rx_fifo_writer.sv
// uart_rx_fifo_writer: oversampling UART receiver (8N1 by default) that pushes
// each good byte, zero-extended, into the write port of the async RX FIFO and
// raises sticky frame/overrun (and optionally parity) error flags.
// Build option: define UART_RX_PARITY_EN to add a parity bit between the data
// bits and the stop bit (PARITY_ODD selects odd parity).
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronized line
// START  | counting to mid start bit, rejecting glitches
// DATA   | sampling data bits LSB first, one every OVS ticks
// PARITY | sampling and checking the parity bit (parity builds only)
// STOP   | sampling the stop bit, writing the byte or flagging an error
module uart_rx_fifo_writer #(
  parameter int FIFO_BW   = 32,
  parameter int DATA_BITS = 8,
  parameter int OVS       = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic               wr_clk,
  input  logic               rst,
  input  logic               rxd,
  input  logic [15:0]        baud_div,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [FIFO_BW-1:0] fifo_din,
  input  logic               err_clr,
  output logic               frame_err,
  output logic               overrun_err,
  output logic               parity_err,
  output logic               rx_busy
);

  localparam int PH_W  = $clog2(OVS);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVS - 1);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(OVS / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state_q, state_d;
  logic                 sync1_q, rxd_s_q, rxd_d_q;
  logic [15:0]          cnt_q, cnt_d;
  logic [15:0]          div_q, div_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 wr_en_q, wr_en_d;
  logic [FIFO_BW-1:0]   din_q, din_d;
  logic                 frame_err_q, overrun_err_q;
  logic                 frame_set, overrun_set;
  logic [15:0]          div_eff;
  logic                 tick;
  logic                 drop_byte;

  // A zero divider would stall the tick counter, so it runs as divide-by-one.
  assign div_eff = (baud_div == 16'd0) ? 16'd1 : baud_div;
  assign tick    = (state_q != IDLE) && (cnt_q == 16'd0);

`ifdef UART_RX_PARITY_EN
  logic parity_err_q, parity_set, par_bad_q, par_bad_d;
  assign drop_byte = par_bad_q;
`else
  assign drop_byte = 1'b0;
`endif

  // Next-state, tick/phase counters, shift register and write strobe.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    wr_en_d     = 1'b0;
    din_d       = din_q;
    frame_set   = 1'b0;
    overrun_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_set  = 1'b0;
    par_bad_d   = par_bad_q;
`endif

    if (state_q != IDLE) begin
      cnt_d = (cnt_q == 16'd0) ? (div_q - 16'd1) : (cnt_q - 16'd1);
    end
    if (tick) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!rxd_s_q && rxd_d_q) begin
          state_d = START;
          div_d   = div_eff;
          cnt_d   = div_eff - 16'd1;
          phase_d = '0;
          idx_d   = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      START: begin
        if (tick && phase_q == PH_HALF) begin
          // Realign the phase so later samples land mid-bit.
          phase_d = '0;
          state_d = rxd_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && phase_q == PH_LAST) begin
          shift_d[idx_q] = rxd_s_q;
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick && phase_q == PH_LAST) begin
          state_d = STOP;
          if (((^shift_q) ^ rxd_s_q) != PARITY_ODD) begin
            parity_set = 1'b1;
            par_bad_d  = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick && phase_q == PH_LAST) begin
          state_d = IDLE;
          if (!rxd_s_q) begin
            frame_set = 1'b1;
          end else if (!drop_byte) begin
            if (fifo_full) begin
              overrun_set = 1'b1;
            end else begin
              wr_en_d = 1'b1;
              din_d   = FIFO_BW'(shift_q);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and sticky flag registers; a set beats a same-cycle clear.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b1;
      rxd_s_q       <= 1'b1;
      rxd_d_q       <= 1'b1;
      cnt_q         <= '0;
      div_q         <= 16'd1;
      phase_q       <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      wr_en_q       <= 1'b0;
      din_q         <= '0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= rxd;
      rxd_s_q       <= sync1_q;
      rxd_d_q       <= rxd_s_q;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      phase_q       <= phase_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      wr_en_q       <= wr_en_d;
      din_q         <= din_d;
      frame_err_q   <= frame_set   | (frame_err_q   & ~err_clr);
      overrun_err_q <= overrun_set | (overrun_err_q & ~err_clr);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity flag and per-frame discard marker.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
    end else begin
      parity_err_q <= parity_set | (parity_err_q & ~err_clr);
      par_bad_q    <= par_bad_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign fifo_wr_en  = wr_en_q;
  assign fifo_din    = din_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign rx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Directed bench for uart_rx_fifo_writer: frames are driven bit-by-bit on rxd
// and the FIFO write port is logged; expected bytes and cycle offsets are
// hand-derived from the frame timing.
module tb_uart_rx_fifo_writer;
  localparam int OVS       = 16;
  localparam int DATA_BITS = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Write appears 155 cycles after rxd is driven low (2 sync + 153), div=1.
  localparam int WR_LAT   = 155 + OVS * PAR_BITS;
  localparam int STOP_OFS = 154 + OVS * PAR_BITS;
  localparam int FRAME_T  = OVS * (DATA_BITS + 2 + PAR_BITS);

  logic        wr_clk = 1'b0;
  logic        rst, rxd, fifo_full, err_clr;
  logic [15:0] baud_div;
  logic        fifo_wr_en;
  logic [31:0] fifo_din;
  logic        frame_err, overrun_err, parity_err, rx_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_start;
  int n0;
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx_fifo_writer #(.FIFO_BW(32), .DATA_BITS(DATA_BITS), .OVS(OVS)) dut (
    .wr_clk      (wr_clk),
    .rst         (rst),
    .rxd         (rxd),
    .baud_div    (baud_div),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_din    (fifo_din),
    .err_clr     (err_clr),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err),
    .rx_busy     (rx_busy)
  );

  always #5 wr_clk = ~wr_clk;

  always @(posedge wr_clk) cyc <= cyc + 1;

  always @(negedge wr_clk) begin
    if (fifo_wr_en) begin
      wr_data.push_back(fifo_din);
      wr_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge wr_clk);
  endtask

  // Called at a negedge; leaves rxd at the stop-bit level when done.
  task automatic send_frame(input logic [7:0] data, input int div, input logic stop_bit);
    int bt;
    bt = OVS * div;
    rxd = 1'b0;
    t_start = cyc;
    repeat (bt) @(negedge wr_clk);
    for (int i = 0; i < DATA_BITS; i++) begin
      rxd = data[i];
      repeat (bt) @(negedge wr_clk);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^data) ^ par_flip;
    repeat (bt) @(negedge wr_clk);
`endif
    rxd = stop_bit;
    repeat (bt) @(negedge wr_clk);
  endtask

  initial begin
    rst = 1'b1; rxd = 1'b1; fifo_full = 1'b0; err_clr = 1'b0; baud_div = 16'd1;
    idle(3);
    check_val("rst_wr_en",   fifo_wr_en,  0);
    check_val("rst_din",     fifo_din,    0);
    check_val("rst_frame",   frame_err,   0);
    check_val("rst_overrun", overrun_err, 0);
    check_val("rst_parity",  parity_err,  0);
    check_val("rst_busy",    rx_busy,     0);
    rst = 1'b0;
    idle(5);

    // Single frame at divide-by-one with exact write latency.
    n0 = wr_data.size();
    send_frame(8'hA5, 1, 1'b1);
    idle(5);
    check_val("a5_count",   wr_data.size() - n0, 1);
    check_val("a5_data",    wr_data[n0], 32'h0000_00A5);
    check_val("a5_time",    wr_cyc[n0] - t_start, WR_LAT);
    check_val("a5_frame",   frame_err,   0);
    check_val("a5_overrun", overrun_err, 0);
    check_val("a5_busy",    rx_busy,     0);

    // Back-to-back frames at baud_div=27.
    baud_div = 16'd27;
    n0 = wr_data.size();
    send_frame(8'h00, 27, 1'b1);
    send_frame(8'hFF, 27, 1'b1);
    send_frame(8'h55, 27, 1'b1);
    idle(20);
    check_val("b2b_count", wr_data.size() - n0, 3);
    check_val("b2b_d0",    wr_data[n0],     32'h00);
    check_val("b2b_d1",    wr_data[n0 + 1], 32'hFF);
    check_val("b2b_d2",    wr_data[n0 + 2], 32'h55);
    check_val("b2b_gap01", wr_cyc[n0 + 1] - wr_cyc[n0],     FRAME_T * 27);
    check_val("b2b_gap12", wr_cyc[n0 + 2] - wr_cyc[n0 + 1], FRAME_T * 27);

    // Short low glitch is rejected at the start-bit midpoint.
    baud_div = 16'd1;
    idle(10);
    n0 = wr_data.size();
    rxd = 1'b0;
    idle(4);
    check_val("glitch_busy_hi", rx_busy, 1);
    rxd = 1'b1;
    idle(30);
    check_val("glitch_count",   wr_data.size() - n0, 0);
    check_val("glitch_busy_lo", rx_busy,     0);
    check_val("glitch_frame",   frame_err,   0);
    check_val("glitch_overrun", overrun_err, 0);

    // Stop bit 0, then a line stuck low never restarts a frame.
    n0 = wr_data.size();
    send_frame(8'h3C, 1, 1'b0);
    check_val("ferr_flag", frame_err, 1);
    idle(400);
    check_val("ferr_count", wr_data.size() - n0, 0);
    check_val("ferr_busy",  rx_busy, 0);
    check_val("din_hold",   fifo_din, 32'h55);
    rxd = 1'b1;
    idle(5);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    idle(2);
    check_val("ferr_clr", frame_err, 0);

    // Overrun: FIFO full at the stop sample.
    n0 = wr_data.size();
    fifo_full = 1'b1;
    send_frame(8'h12, 1, 1'b1);
    fifo_full = 1'b0;
    idle(5);
    check_val("ovr_count", wr_data.size() - n0, 0);
    check_val("ovr_flag",  overrun_err, 1);
    check_val("ovr_frame", frame_err,   0);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    idle(2);
    check_val("ovr_clr", overrun_err, 0);

    // err_clr in the same cycle as a new overrun: the set wins.
    fifo_full = 1'b1;
    fork
      send_frame(8'h12, 1, 1'b1);
      begin
        repeat (STOP_OFS) @(negedge wr_clk);
        err_clr = 1'b1;
        @(negedge wr_clk);
        err_clr = 1'b0;
      end
    join
    fifo_full = 1'b0;
    idle(5);
    check_val("ovr_set_wins", overrun_err, 1);
    check_val("ovr2_count",   wr_data.size() - n0, 0);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    idle(5);

    // Reset mid-DATA aborts the frame; the next frame is received normally.
    n0 = wr_data.size();
    rxd = 1'b0;
    idle(40);
    check_val("abort_busy_hi", rx_busy, 1);
    rst = 1'b1;
    rxd = 1'b1;
    idle(3);
    check_val("abort_busy_lo", rx_busy, 0);
    check_val("abort_din",     fifo_din, 0);
    rst = 1'b0;
    idle(200);
    check_val("abort_count", wr_data.size() - n0, 0);
    send_frame(8'h7E, 1, 1'b1);
    idle(5);
    check_val("7e_count",   wr_data.size() - n0, 1);
    check_val("7e_data",    wr_data[n0], 32'h7E);
    check_val("7e_frame",   frame_err,   0);
    check_val("7e_overrun", overrun_err, 0);

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit discards the byte and flags parity_err.
    n0 = wr_data.size();
    par_flip = 1'b1;
    send_frame(8'h6B, 1, 1'b1);
    par_flip = 1'b0;
    idle(5);
    check_val("par_count", wr_data.size() - n0, 0);
    check_val("par_flag",  parity_err,  1);
    check_val("par_frame", frame_err,   0);
    check_val("par_ovr",   overrun_err, 0);
`else
    check_val("par_tied", parity_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
